seq_multiplier: RTL

//   Parametrised unsigned/signed WIDTHxWIDTH multiplier using radix-2 shift-add, one partial product per cycle.

---
 rtl/seq_multiplier_pkg.sv | 30 +++
 rtl/seq_multiplier.sv | 112 +++++++++++
 2 files changed

// File: rtl/seq_multiplier_pkg.sv
// Shared types and helpers for the shift-add multiplier.
// Helpers operate on MAX_W-bit vectors with a runtime width, so one package serves every WIDTH.
package mult_pkg;

   localparam int unsigned MAX_W = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   // Magnitude of the w-bit two's-complement value held in the low bits of v.
   function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] v, input int unsigned w);
      logic [MAX_W-1:0] mask;
      logic [MAX_W-1:0] sh;
      mask = (MAX_W'(1) << w) - MAX_W'(1);
      sh   = v >> (w - 1);
      if (sh[0]) return (~v + MAX_W'(1)) & mask;
      else       return v & mask;
   endfunction

   // Two's-complement negate of the low w bits of v.
   function automatic logic [MAX_W-1:0] neg2w(input logic [MAX_W-1:0] v, input int unsigned w);
      logic [MAX_W-1:0] mask;
      mask = (MAX_W'(1) << w) - MAX_W'(1);
      return (~v + MAX_W'(1)) & mask;
   endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier, one partial product per cycle, runtime signed/unsigned mode.
// Signed operands are reduced to magnitudes up front and the sign is reapplied on entry to DONE.
module seq_multiplier
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_en,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               ready,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] p
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam int unsigned PW    = 2 * WIDTH;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplr_q,  mplr_d;
   logic [PW-1:0]    acc_q,   acc_d;
   logic             neg_q,   neg_d;
   logic [PW-1:0]    p_q,     p_d;
   logic             done_q,  done_d;

   logic [PW-1:0]    add_term;
   logic [PW-1:0]    acc_sum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= '0;
         mcand_q <= '0;
         mplr_q  <= '0;
         acc_q   <= '0;
         neg_q   <= 1'b0;
         p_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         acc_q   <= acc_d;
         neg_q   <= neg_d;
         p_q     <= p_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      mcand_d  = mcand_q;
      mplr_d   = mplr_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      p_d      = p_q;
      done_d   = 1'b0;
      add_term = PW'(mcand_q) << count_q;
      acc_sum  = mplr_q[0] ? (acc_q + add_term) : acc_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CALC;
               count_d = '0;
               acc_d   = '0;
               p_d     = '0;
               if (signed_en) begin
                  mcand_d = WIDTH'(abs_w(MAX_W'(a), WIDTH));
                  mplr_d  = WIDTH'(abs_w(MAX_W'(b), WIDTH));
                  neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
               end else begin
                  mcand_d = a;
                  mplr_d  = b;
                  neg_d   = 1'b0;
               end
            end
         end
         CALC: begin
            acc_d   = acc_sum;
            mplr_d  = mplr_q >> 1;
            count_d = count_q + CNT_W'(1);
            // The final partial product is folded in here so p is ready the first DONE cycle.
            if (count_q == CNT_W'(WIDTH - 1)) begin
               state_d = DONE;
               done_d  = 1'b1;
               p_d     = neg_q ? PW'(neg2w(MAX_W'(acc_sum), PW)) : acc_sum;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign ready = (state_q == IDLE);
   assign busy  = (state_q != IDLE);
   assign done  = done_q;
   assign p     = p_q;

endmodule
